// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, load-size codes and writeback FSM state type (commit ports gated by DIFFTEST_EN)
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

package wb_stage_pkg;
    localparam int CPU_WIDTH = `CPU_WIDTH;
    localparam int REG_ADDRW = `REG_ADDRW;
    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WB} wb_state_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-stage handshake, load response and register-file write bundle (DIFFTEST_EN adds commit trace)
interface wb_stage_if;
    import wb_stage_pkg::*;
    logic                 i_valid;
    logic                 o_ready;
    logic                 i_rd_wen;
    logic [REG_ADDRW-1:0] i_rd_addr;
    logic [CPU_WIDTH-1:0] i_alu_res;
    logic                 i_is_load;
    logic [1:0]           i_ld_size;
    logic                 i_ld_unsigned;
    logic [2:0]           i_addr_lo;
    logic                 i_mem_rvalid;
    logic [CPU_WIDTH-1:0] i_mem_rdata;
    logic                 o_wen;
    logic [REG_ADDRW-1:0] o_waddr;
    logic [CPU_WIDTH-1:0] o_wdata;
`ifdef DIFFTEST_EN
    logic [CPU_WIDTH-1:0] i_pc;
    logic [31:0]          i_inst;
    logic                 o_commit_valid;
    logic [CPU_WIDTH-1:0] o_commit_pc;
    logic [31:0]          o_commit_inst;
`endif

    modport master (
`ifdef DIFFTEST_EN
        output i_pc, i_inst,
        input  o_commit_valid, o_commit_pc, o_commit_inst,
`endif
        output i_valid, i_rd_wen, i_rd_addr, i_alu_res, i_is_load, i_ld_size,
               i_ld_unsigned, i_addr_lo, i_mem_rvalid, i_mem_rdata,
        input  o_ready, o_wen, o_waddr, o_wdata
    );

    modport slave (
`ifdef DIFFTEST_EN
        input  i_pc, i_inst,
        output o_commit_valid, o_commit_pc, o_commit_inst,
`endif
        input  i_valid, i_rd_wen, i_rd_addr, i_alu_res, i_is_load, i_ld_size,
               i_ld_unsigned, i_addr_lo, i_mem_rvalid, i_mem_rdata,
        output o_ready, o_wen, o_waddr, o_wdata
    );
endinterface

// File: rtl/wb_stage_ld_extend.sv
// ld_extend: combinational load-data shift, size select and sign/zero extension
module ld_extend
    import wb_stage_pkg::*;
(
    input  logic [CPU_WIDTH-1:0] rdata_i,
    input  logic [2:0]           addr_lo_i,
    input  logic [1:0]           size_i,
    input  logic                 uns_i,
    output logic [CPU_WIDTH-1:0] data_o
);
    logic [CPU_WIDTH-1:0] shifted;

    // Bring the addressed byte to bit 0 (zero-filled), then keep and extend the sized field
    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        data_o  = size_i == LD_B ? {{(CPU_WIDTH-8){!uns_i && shifted[7]}}, shifted[7:0]} :
                  size_i == LD_H ? {{(CPU_WIDTH-16){!uns_i && shifted[15]}}, shifted[15:0]} :
                  size_i == LD_W ? {{(CPU_WIDTH-32){!uns_i && shifted[31]}}, shifted[31:0]} :
                  shifted;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage driving the register-file write port; DIFFTEST_EN adds a commit trace
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    wb_stage_if.slave bus
);
    wb_state_t            state_q;
    logic                 rd_wen_q;
    logic [REG_ADDRW-1:0] rd_addr_q;
    logic [1:0]           ld_size_q;
    logic                 ld_uns_q;
    logic [2:0]           addr_lo_q;
    logic                 wen_q;
    logic [REG_ADDRW-1:0] waddr_q;
    logic [CPU_WIDTH-1:0] wdata_q;
    logic [CPU_WIDTH-1:0] ld_data_d;
    logic                 ld_wr_d;
    logic                 alu_wr_d;
`ifdef DIFFTEST_EN
    logic [CPU_WIDTH-1:0] pc_q;
    logic [31:0]          inst_q;
    logic                 cvalid_q;
    logic [CPU_WIDTH-1:0] cpc_q;
    logic [31:0]          cinst_q;
`endif

    ld_extend u_ld_extend (
        .rdata_i   (bus.i_mem_rdata),
        .addr_lo_i (addr_lo_q),
        .size_i    (ld_size_q),
        .uns_i     (ld_uns_q),
        .data_o    (ld_data_d)
    );

    assign ld_wr_d      = rd_wen_q && rd_addr_q != '0;
    assign alu_wr_d     = bus.i_rd_wen && bus.i_rd_addr != '0;
    assign bus.o_ready  = !i_rst && state_q != WAIT_MEM;
    assign bus.o_wen    = wen_q;
    assign bus.o_waddr  = waddr_q;
    assign bus.o_wdata  = wdata_q;
`ifdef DIFFTEST_EN
    assign bus.o_commit_valid = cvalid_q;
    assign bus.o_commit_pc    = cpc_q;
    assign bus.o_commit_inst  = cinst_q;
`endif

    // Writeback FSM: accept from IDLE/WB, park in WAIT_MEM for a load response, write once in WB
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            rd_wen_q  <= 1'b0;
            rd_addr_q <= '0;
            ld_size_q <= LD_B;
            ld_uns_q  <= 1'b0;
            addr_lo_q <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
`ifdef DIFFTEST_EN
            pc_q      <= '0;
            inst_q    <= '0;
            cvalid_q  <= 1'b0;
            cpc_q     <= '0;
            cinst_q   <= '0;
`endif
        end else begin
            wen_q <= 1'b0;
`ifdef DIFFTEST_EN
            cvalid_q <= 1'b0;
`endif
            if (state_q == WAIT_MEM) begin
                if (bus.i_mem_rvalid) begin
                    state_q <= WB;
                    wen_q   <= ld_wr_d;
                    if (ld_wr_d) begin
                        waddr_q <= rd_addr_q;
                        wdata_q <= ld_data_d;
                    end
`ifdef DIFFTEST_EN
                    cvalid_q <= 1'b1;
                    cpc_q    <= pc_q;
                    cinst_q  <= inst_q;
`endif
                end
            end else if (bus.i_valid) begin
                rd_wen_q  <= bus.i_rd_wen;
                rd_addr_q <= bus.i_rd_addr;
                ld_size_q <= bus.i_ld_size;
                ld_uns_q  <= bus.i_ld_unsigned;
                addr_lo_q <= bus.i_addr_lo;
`ifdef DIFFTEST_EN
                pc_q      <= bus.i_pc;
                inst_q    <= bus.i_inst;
`endif
                if (bus.i_is_load) begin
                    state_q <= WAIT_MEM;
                end else begin
                    state_q <= WB;
                    wen_q   <= alu_wr_d;
                    if (alu_wr_d) begin
                        waddr_q <= bus.i_rd_addr;
                        wdata_q <= bus.i_alu_res;
                    end
`ifdef DIFFTEST_EN
                    cvalid_q <= 1'b1;
                    cpc_q    <= bus.i_pc;
                    cinst_q  <= bus.i_inst;
`endif
                end
            end else begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: random and directed stimulus checked every cycle against a transaction-level writeback model
module tb_wb_stage;
    import wb_stage_pkg::*;
    localparam int A = REG_ADDRW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   run = 1'b0;
    int   errs = 0;
    int   checks = 0;
    logic [63:0] d_pc = '0;
    logic [31:0] d_inst = '0;

    always #5 clk = ~clk;

    wb_stage_if bus();
    wb_stage dut (.i_clk(clk), .i_rst(rst), .bus(bus));
`ifdef DIFFTEST_EN
    assign bus.i_pc   = d_pc;
    assign bus.i_inst = d_inst;
`endif

    bit          m_pend;
    logic        m_rd_wen;
    logic [A-1:0] m_rd;
    logic [1:0]  m_size;
    logic        m_uns;
    logic [2:0]  m_lo;
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    logic        m_wen;
    logic [A-1:0] m_waddr;
    logic [63:0] m_wdata;
    logic        m_cv;
    logic [63:0] m_cpc;
    logic [31:0] m_cinst;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] extract(logic [63:0] rd, int lo, int size, bit uns);
        logic [63:0] v = '0;
        int n = 1 << size;
        bit s;
        for (int i = 0; i < n; i++) if (lo + i < 8) v[8*i +: 8] = rd[8*(lo+i) +: 8];
        s = !uns && n < 8 && v[8*n-1];
        for (int i = n; i < 8; i++) v[8*i +: 8] = s ? 8'hFF : 8'h00;
        return v;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
        m_cv = 0; m_cpc = '0; m_cinst = '0;
    endtask

    task automatic retire(logic [63:0] v);
        if (m_rd_wen && m_rd != '0) begin
            m_wen = 1; m_waddr = m_rd; m_wdata = v;
        end
        m_cv = 1; m_cpc = m_pc; m_cinst = m_inst;
    endtask

    task automatic model_step();
        if (rst) return;
        m_wen = 0; m_cv = 0;
        if (m_pend) begin
            if (bus.i_mem_rvalid) begin
                m_pend = 0;
                retire(extract(bus.i_mem_rdata, int'(m_lo), int'(m_size), m_uns));
            end
        end else if (bus.i_valid) begin
            m_rd_wen = bus.i_rd_wen; m_rd = bus.i_rd_addr; m_pc = d_pc; m_inst = d_inst;
            if (bus.i_is_load) begin
                m_pend = 1; m_size = bus.i_ld_size; m_uns = bus.i_ld_unsigned; m_lo = bus.i_addr_lo;
            end else retire(bus.i_alu_res);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic set_rst(bit v);
        rst = v;
        if (v) model_reset();
    endtask

    task automatic set_in(bit v, bit we, int rd, logic [63:0] alu, bit ld, int sz, bit u, int lo,
                          bit rv, logic [63:0] rdata, logic [63:0] pc);
        bus.i_valid = v; bus.i_rd_wen = we; bus.i_rd_addr = A'(rd); bus.i_alu_res = alu;
        bus.i_is_load = ld; bus.i_ld_size = 2'(sz); bus.i_ld_unsigned = u; bus.i_addr_lo = 3'(lo);
        bus.i_mem_rvalid = rv; bus.i_mem_rdata = rdata; d_pc = pc; d_inst = $urandom;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) if (run) begin
        chk("ready", bus.o_ready, !rst && !m_pend);
        chk("wen", bus.o_wen, m_wen);
        chk("waddr", bus.o_waddr, m_waddr);
        chk("wdata", bus.o_wdata, m_wdata);
`ifdef DIFFTEST_EN
        chk("commit_valid", bus.o_commit_valid, m_cv);
        if (m_cv) begin
            chk("commit_pc", bus.o_commit_pc, m_cpc);
            chk("commit_inst", bus.o_commit_inst, m_cinst);
        end
`endif
    end

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_rd_wen = 0; m_rd = '0; m_size = '0; m_uns = 0; m_lo = '0; m_pc = '0; m_inst = '0;
        #1 set_rst(1);
        run = 1;
        chk("model_sb", extract(64'h0000_0000_8000_0000, 3, 0, 0), 64'hFFFF_FFFF_FFFF_FF80);
        chk("model_uw", extract(64'hDEAD_BEEF_0000_0000, 4, 2, 1), 64'h0000_0000_DEAD_BEEF);
        chk("model_sh", extract(64'h0000_0000_8001_0000, 2, 1, 0), 64'hFFFF_FFFF_FFFF_8001);
        chk("model_dw_off", extract(64'h8877_6655_4433_2211, 5, 3, 0), 64'h0000_0000_0088_7766);
        for (int i = 0; i < 5; i++) begin
            set_in(1, 1, i + 1, {$urandom, $urandom}, i[0], 0, 0, 0, 1, 0, 0);
            tick();
            chk("rst_ready", bus.o_ready, 0);
            chk("rst_wen", bus.o_wen, 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_rst(0);
        @(negedge clk);
        chk("post_rst_ready", bus.o_ready, 1);
        chk("post_rst_wdata", bus.o_wdata, 0);
        chk("post_rst_waddr", bus.o_waddr, 0);

        set_in(1, 1, 5, 64'h11, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("alu_x5", {bus.o_wen, 3'b0, bus.o_waddr, bus.o_wdata[7:0]}, {1'b1, 3'b0, 5'd5, 8'h11});
        set_in(1, 1, 6, 64'h22, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("alu_x6", {bus.o_wen, 3'b0, bus.o_waddr, bus.o_wdata[7:0]}, {1'b1, 3'b0, 5'd6, 8'h22});
        set_in(1, 1, 0, 64'h33, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("alu_x0_wen", bus.o_wen, 0);
        chk("alu_x0_hold", bus.o_wdata, 64'h22);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        set_in(1, 1, 7, 0, 1, 0, 0, 3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        tick();
        chk("ld_wait_ready", bus.o_ready, 0);
        set_in(1, 1, 3, 64'h55, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_wait_ready", bus.o_ready, 0);
            chk("ld_wait_wen", bus.o_wen, 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_8000_0000, 0);
        tick();
        chk("ld_sb", bus.o_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("ld_sb_wen", {bus.o_wen, bus.o_ready, 3'b0, bus.o_waddr}, {2'b11, 3'b0, 5'd7});

        set_in(1, 1, 8, 0, 1, 2, 1, 4, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hDEAD_BEEF_0000_0000, 0);
        tick();
        chk("ld_uw", bus.o_wdata, 64'h0000_0000_DEAD_BEEF);
        set_in(1, 1, 9, 0, 1, 1, 0, 2, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_8001_0000, 0);
        tick();
        chk("ld_sh", bus.o_wdata, 64'hFFFF_FFFF_FFFF_8001);
        chk("ld_sh_addr", bus.o_waddr, 9);

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1234, 0);
        tick();
        chk("spurious_wen", bus.o_wen, 0);
        tick();
        chk("spurious_wen2", bus.o_wen, 0);

        set_in(1, 1, 10, 0, 1, 3, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_rst(1);
        tick();
        set_rst(0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hABCD, 0);
        tick();
        chk("late_rvalid_wen", bus.o_wen, 0);
        chk("late_rvalid_ready", bus.o_ready, 1);

        set_in(1, 0, 12, 64'h99, 0, 0, 0, 0, 0, 0, 64'h8000_0004);
        tick();
        chk("nowrite_wen", bus.o_wen, 0);
`ifdef DIFFTEST_EN
        chk("dt_valid", bus.o_commit_valid, 1);
        chk("dt_pc", bus.o_commit_pc, 64'h8000_0004);
`endif
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
`ifdef DIFFTEST_EN
        chk("dt_once", bus.o_commit_valid, 0);
`endif

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                set_rst(1);
                tick();
                set_rst(0);
            end
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 31),
                   {$urandom, $urandom}, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                   {$urandom, $urandom}, {$urandom, $urandom});
            tick();
        end
        @(negedge clk);
        run = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
